aes_mode_stream_core: RTL

//  Streaming, multi-mode AES-128 encryption engine; next generation of the fixed-width CTR/CBC wrapper.

---
 rtl/aes_mode_stream_if.sv | 34 +++
 rtl/aes_mode_stream_core.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/aes_mode_stream_if.sv
// aes_mode_stream_if: message setup, plaintext/ciphertext valid-ready streams and status of the AES stream core.
// AES_MODE_TAG_EN widens out_data to 132 bits (mode tag in [131:128]).
interface aes_mode_stream_if #(
   parameter int MAX_BLOCKS = 4
) ();
   localparam int BW = $clog2(MAX_BLOCKS + 1);
`ifdef AES_MODE_TAG_EN
   localparam int DW = 132;
`else
   localparam int DW = 128;
`endif
   logic          start;
   logic [1:0]    mode;
   logic [127:0]  key;
   logic [127:0]  iv;
   logic [BW-1:0] nblocks;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;
   logic          err;
   modport master (
      output start, mode, key, iv, nblocks, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy, done, err
   );
   modport slave (
      input  start, mode, key, iv, nblocks, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy, done, err
   );
endinterface

// File: rtl/aes_mode_stream_core.sv
// aes_mode_stream_core: streaming ECB/CTR/CBC AES-128 encryptor around one combinational aes_ebc core.
// Optional AES_MODE_TAG_EN prepends a 4-bit mode tag to out_data.
module aes_ebc (
   input  logic [127:0] key_i,
   input  logic [127:0] pt_i,
   output logic [127:0] ct_o
);
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         r = b[i] ? r ^ x : r;
         x = xt(x);
      end
      return r;
   endfunction
   // S-box computed as the GF(2^8) inverse a^254 followed by the affine map
   function automatic logic [7:0] sb(input logic [7:0] a);
      logic [7:0] p, v;
      p = a;
      v = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gm(p, p);
         v = gm(v, p);
      end
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction
   function automatic logic [127:0] ssb(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = sb(s[127-8*(4*((c+r)%4)+r) -: 8]);
      return o;
   endfunction
   function automatic logic [127:0] mc(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return o;
   endfunction
   logic [127:0] s, k;
   logic [7:0]   rc;
   // Round keys are expanded on the fly alongside the rounds
   always_comb begin
      k  = key_i;
      s  = pt_i ^ key_i;
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         k[127:96] = k[127:96] ^ {sb(k[23:16]) ^ rc, sb(k[15:8]), sb(k[7:0]), sb(k[31:24])};
         k[95:64]  = k[95:64] ^ k[127:96];
         k[63:32]  = k[63:32] ^ k[95:64];
         k[31:0]   = k[31:0] ^ k[63:32];
         rc = xt(rc);
         s  = ssb(s);
         s  = r < 10 ? mc(s) : s;
         s  = s ^ k;
      end
      ct_o = s;
   end
endmodule

module aes_mode_stream_core #(
   parameter int MAX_BLOCKS = 4,
   parameter int CTR_WIDTH  = 32
) (
   input logic              clk,
   input logic              rst_n,
   aes_mode_stream_if.slave bus
);
   localparam int BW = $clog2(MAX_BLOCKS + 1);
   localparam logic [1:0] CTR = 2'b01, CBC = 2'b10;
   localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;
   typedef enum logic [2:0] {IDLE, WAIT_IN, ENC, OUT, DONE} state_t;
   state_t        state_q, state_d;
   logic [127:0]  key_q, ctr_q, chain_q, ain_q, pt_q, res_q, enc;
   logic [1:0]    mode_q;
   logic [BW-1:0] nb_q, idx_q;
   logic          err_q, start_ok, last;
   aes_ebc u_aes (.key_i(key_q), .pt_i(ain_q), .ct_o(enc));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   always_comb begin
      start_ok = bus.mode != 2'b11 && bus.nblocks != '0 && bus.nblocks <= BW'(MAX_BLOCKS);
      last     = idx_q == nb_q - BW'(1);
      state_d  = state_q;
      case (state_q)
         IDLE:    state_d = bus.start && start_ok ? WAIT_IN : IDLE;
         WAIT_IN: state_d = bus.in_valid ? ENC : WAIT_IN;
         ENC:     state_d = OUT;
         OUT:     state_d = !bus.out_ready ? OUT : last ? DONE : WAIT_IN;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      bus.in_ready  = state_q == WAIT_IN;
      bus.out_valid = state_q == OUT;
      bus.busy      = state_q != IDLE;
      bus.done      = state_q == DONE;
      bus.err       = err_q;
`ifdef AES_MODE_TAG_EN
      bus.out_data  = {!bus.out_valid ? 4'h0 : mode_q == CTR ? 4'h0 : mode_q == CBC ? 4'hf : 4'ha, res_q};
`else
      bus.out_data  = res_q;
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         key_q   <= '0;
         ctr_q   <= '0;
         chain_q <= '0;
         ain_q   <= '0;
         pt_q    <= '0;
         res_q   <= '0;
         mode_q  <= '0;
         nb_q    <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= state_q == IDLE && bus.start && !start_ok;
         if (state_q == IDLE && bus.start && start_ok) begin
            mode_q  <= bus.mode;
            key_q   <= bus.key;
            ctr_q   <= bus.iv;
            chain_q <= bus.iv;
            nb_q    <= bus.nblocks;
            idx_q   <= '0;
         end
         if (state_q == WAIT_IN && bus.in_valid) begin
            pt_q  <= bus.in_data;
            ain_q <= mode_q == CTR ? ctr_q : mode_q == CBC ? bus.in_data ^ chain_q : bus.in_data;
         end
         if (state_q == ENC) res_q <= mode_q == CTR ? pt_q ^ enc : enc;
         // Only the low CTR_WIDTH counter bits advance; the upper bits stay as loaded
         if (state_q == OUT && bus.out_ready) begin
            ctr_q   <= (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
            chain_q <= res_q;
            idx_q   <= idx_q + BW'(1);
         end
      end
endmodule
